// File: rtl/truth_table_engine.sv
// Runtime-writable 2^N x 1 truth table with registered lookups and an optional
// full-table stream (sweep), enabled by defining TRUTH_TABLE_SWEEP_EN.
module truth_table_engine #(
  parameter int unsigned           N    = 4,
  parameter logic [(1<<N)-1:0]     INIT = 16'hD5FD
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [N-1:0] wr_addr_i,
  input  logic         wr_data_i,
  output logic         wr_err_o,
  input  logic         in_valid_i,
  input  logic [N-1:0] in_addr_i,
  output logic         out_valid_o,
  output logic         out_f_o,
  input  logic         sweep_start_i,
  output logic         sweep_busy_o,
  output logic         sw_valid_o,
  input  logic         sw_ready_i,
  output logic [N-1:0] sw_addr_o,
  output logic         sw_f_o,
  output logic         sweep_done_o,
  output logic [N:0]   sw_ones_o
);

  localparam int unsigned DEPTH = 1 << N;

  logic [DEPTH-1:0] table_q, table_d;
  logic             out_valid_q, out_f_q, out_f_d;
  logic             wr_ok_s;

  // Table write path; the lookup below reads table_q, so a same-edge lookup sees the old value
  always_comb begin
    table_d = table_q;
    if (wr_ok_s) begin
      table_d[wr_addr_i] = wr_data_i;
    end else begin
      table_d = table_q;
    end
  end

  // Lookup result; out_f holds its last value when no request is present
  always_comb begin
    out_f_d = out_f_q;
    if (in_valid_i) begin
      out_f_d = table_q[in_addr_i];
    end else begin
      out_f_d = out_f_q;
    end
  end

  // Table and lookup registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      table_q     <= INIT;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
    end else begin
      table_q     <= table_d;
      out_valid_q <= in_valid_i;
      out_f_q     <= out_f_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_f_o     = out_f_q;

`ifdef TRUTH_TABLE_SWEEP_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] CNT_LAST = N'(DEPTH - 1);
  localparam logic [N-1:0] CNT_ONE  = N'(1'b1);

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N:0]     ones_q, ones_d, sw_ones_q, sw_ones_d;
  logic           wr_err_q, wr_err_d;
  logic           run_s, busy_s, beat_f_s;

  assign run_s    = (state_q == S_RUN);
  assign busy_s   = (state_q != S_IDLE);
  assign beat_f_s = table_q[cnt_q];
  assign wr_ok_s  = wr_en_i & ~busy_s;
  assign wr_err_d = wr_en_i & busy_s;

  // Sweep next-state: count beats on each accepted transfer, latch the ones total on DONE entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    sw_ones_d = sw_ones_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_start_i) begin
          state_d = S_RUN;
          cnt_d   = {N{1'b0}};
          ones_d  = {(N+1){1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (sw_ready_i) begin
          cnt_d  = cnt_q + CNT_ONE;
          ones_d = ones_q + {{N{1'b0}}, beat_f_s};
          if (cnt_q == CNT_LAST) begin
            state_d   = S_DONE;
            sw_ones_d = ones_q + {{N{1'b0}}, beat_f_s};
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= {N{1'b0}};
      ones_q    <= {(N+1){1'b0}};
      sw_ones_q <= {(N+1){1'b0}};
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      sw_ones_q <= sw_ones_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Stream outputs decode only registered state, so sw_ready never reaches sw_valid
  assign sweep_busy_o = busy_s;
  assign sw_valid_o   = run_s;
  assign sw_addr_o    = run_s ? cnt_q : {N{1'b0}};
  assign sw_f_o       = run_s & beat_f_s;
  assign sweep_done_o = (state_q == S_DONE);
  assign sw_ones_o    = sw_ones_q;
  assign wr_err_o     = wr_err_q;
`else
  logic unused_sweep_s;

  assign unused_sweep_s = ^{sweep_start_i, sw_ready_i};
  assign wr_ok_s        = wr_en_i;
  assign sweep_busy_o   = 1'b0;
  assign sw_valid_o     = 1'b0;
  assign sw_addr_o      = {N{1'b0}};
  assign sw_f_o         = 1'b0;
  assign sweep_done_o   = 1'b0;
  assign sw_ones_o      = {(N+1){1'b0}};
  assign wr_err_o       = 1'b0;
`endif

endmodule
